count_checker: RTL
==================

# count_checker

Sequence checker for the free-running 3-bit counter: the receiving end of the counter's `Q` bus. It samples the count on every enabled clock edge and locks onto the mod-2^WIDTH increment sequence. It then flags any skipped, repeated or backward step and keeps a saturating error tally. It sits next to the counter in the lab designs and gives a self-checking pass/fail signal instead of reading waveforms by eye.

## Interface
- `WIDTH`, 3: width of the monitored count.
- `LOCK_COUNT`, 2: consecutive correct increments required to enter LOCKED (range 1..15).
- `ERR_W`, 8: width of the error counter.

- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `q_in`  in  WIDTH  count value under test.
- `en`  in  1  `q_in` is sampled on this edge when high.
- `err_clr`  in  1  synchronous clear of `err_count`.
- `locked`  out  1  checker is tracking a valid sequence.
- `err`  out  1  one-cycle pulse: bad step detected while LOCKED.
- `wrap`  out  1  one-cycle pulse: valid step from 2^WIDTH-1 to 0 while LOCKED.
- `expected`  out  WIDTH  next value the checker expects (`prev+1` mod 2^WIDTH).
- `err_count`  out  ERR_W  saturating count of `err` pulses.

## Operation
- **Registers.** The block holds `prev` (WIDTH bits), `good_cnt` (4 bits) and a 2-bit state. The states are UNLOCKED, ACQUIRE and LOCKED.
- **Step test.** A step is good when `q_in == prev + 1` mod 2^WIDTH. The add wraps naturally at WIDTH bits.
- **UNLOCKED** (reset state), on `en`:
  - `prev <= q_in`, `good_cnt <= 0`.
  - Go to ACQUIRE.
  - No pulses.
- **ACQUIRE**, on `en`:
  - `prev <= q_in` always.
  - Good step: `good_cnt <= good_cnt+1`. If `good_cnt+1 == LOCK_COUNT`, go to LOCKED and clear `good_cnt`.
  - Bad step: `good_cnt <= 0` and stay in ACQUIRE.
  - `err` never fires in this state.
- **LOCKED**, on `en`:
  - Good step: `prev <= q_in`. Pulse `wrap` if `prev == 2^WIDTH-1`.
  - Bad step: pulse `err`, increment `err_count` (saturates at 2^ERR_W-1), `prev <= q_in` (resynchronise), `good_cnt <= 0`, go to ACQUIRE.
- **`en` low.** All registers hold. `err` and `wrap` are 0.
- **`err_clr`.** Sets `err_count <= 0`. Clear wins over a simultaneous increment, but `err` still pulses in that cycle.
- **Output decode.**
  - `locked` = (state == LOCKED).
  - `expected` = `prev + 1` (in UNLOCKED this is 1, since `prev` resets to 0).

## Timing
- **Output registration.**
  - All outputs are registered or decoded from registers only. None is combinational from `q_in`.
  - The outputs update on the same rising edge that samples `q_in`, so they are valid during the following cycle.
- **Pulse width.** `err` and `wrap` are high for exactly one cycle per event.
- **Lock latency.** `LOCK_COUNT+1` enabled samples from UNLOCKED. With the default, samples 0,1,2 mean `locked` is high after the third sampling edge.
- **Recovery after an error.** Re-lock needs `LOCK_COUNT` further good steps; no return to UNLOCKED is needed.
- **Reset.**
  - While `reset` is asserted, and immediately on assertion (mid-operation included): state=UNLOCKED, `prev`=0, `good_cnt`=0, `locked`=0, `err`=0, `wrap`=0, `err_count`=0, `expected`=1.
  - The first enabled edge after deassertion is treated as an UNLOCKED sample.
- **Simultaneous events.** `err` and `wrap` are mutually exclusive. A bad step from 7 to 0 is `err` only.

## Test plan
- **Reset and first lock.** Drive the real 3-bit counter, `reset` high 100 ns, `en`=1, 100 ns clock. Require all outputs at reset values during reset. `q_in` 0,1,2 → `locked`=1 after the third edge with `expected`=3. `err_count` stays 0 over 8 cycles.
- **Wrap.** Locked at 6, then samples 7,0 → single-cycle `wrap` after the 0 sample, `err`=0, `expected`=1.
- **Skip.** Locked at 3, then sample 5 → `err` pulses once, `err_count`=1, `locked`=0. Then 6,7 → `locked`=1 again, `err_count` stays 1.
- **Hold and repeat.** Locked at 2. `en`=0 for 3 cycles with `q_in` changing randomly → no state change, no pulses. Then `en`=1 with sample 2 (repeat) → `err`, `err_count`+1.
- **Saturation and clear.** `ERR_W`=2. Force 5 errors, each followed by re-lock → `err_count` stops at 3. Assert `err_clr` together with a 6th error → `err` pulses, `err_count`=0.
- **Reset mid-lock.** Pulse `reset` for 30 ns between edges while LOCKED with `err_count`=2 → `locked`, `err_count` and `expected` drop to 0/0/1 before the next edge. Re-lock takes 3 samples.

Source files
------------

// File: rtl/count_checker.sv
// Sequence checker for a free-running mod-2^WIDTH counter: locks onto the
// increment sequence, flags bad steps and keeps a saturating error tally.
module count_checker #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             en,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [WIDTH-1:0] expected,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned GW = 4;
  localparam logic [GW-1:0] LOCK_TARGET = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] prev;
  logic [GW-1:0]    good_cnt;

  logic [WIDTH-1:0] prev_inc;
  logic [GW-1:0]    good_inc;
  logic             step_ok;
  logic             prev_max;
  logic             err_sat;

  assign prev_inc = prev + WIDTH'(1);
  assign good_inc = good_cnt + GW'(1);
  assign step_ok  = (q_in == prev_inc);
  assign prev_max = (prev == {WIDTH{1'b1}});
  assign err_sat  = (err_count == {ERR_W{1'b1}});

  // expected is kept as its own register so it mirrors prev+1 without a
  // combinational output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= UNLOCKED;
      prev      <= '0;
      good_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      expected  <= WIDTH'(1);
      err_count <= '0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      if (err_clr) err_count <= '0;
      if (en) begin
        prev     <= q_in;
        expected <= q_in + WIDTH'(1);
        case (state)
          UNLOCKED: begin
            good_cnt <= '0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            if (step_ok) begin
              if (good_inc == LOCK_TARGET) begin
                good_cnt <= '0;
                state    <= LOCKED;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_inc;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (step_ok) begin
              wrap <= prev_max;
            end else begin
              // Resynchronise on the bad value and re-acquire from there.
              err      <= 1'b1;
              good_cnt <= '0;
              state    <= ACQUIRE;
              locked   <= 1'b0;
              if (!err_clr && !err_sat) err_count <= err_count + ERR_W'(1);
            end
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
